lc_request_sequencer: RTL and testbench
=======================================

Name: lc_request_sequencer

Overview:
- Upstream front-end for the MCSE top-level lifecycle inputs.
- Accepts 32-bit host writes over a valid/ready port and assembles a 256-bit transition ID and a 256-bit authentication ID.
- On a start command, drives the ordered lifecycle sequence into the MCSE:
  - one-cycle transition request with the transition ID;
  - programmable gap;
  - authentication ID with valid held for a programmable window.
- Reports busy/done/err to the host.

Parameters:
- WORD_W, 32, host write word width
- ID_W, 256, transition/authentication ID width; ID_W/WORD_W words per ID (8 by default)
- AUTH_GAP, 4, idle cycles between request pulse and authentication valid; 0 allowed
- AUTH_HOLD, 8, cycles lc_authentication_valid stays high; must be >=1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_valid  in  1  host write valid
- wr_ready  out  1  host write ready
- wr_sel  in  1  write target: 0 = transition ID, 1 = authentication ID
- wr_data  in  WORD_W  write word
- start  in  1  begin sequence (level sampled in IDLE)
- abort  in  1  cancel sequence / discard loaded IDs
- lc_transition_id  out  ID_W  transition ID to MCSE
- lc_transition_request_in  out  1  transition request pulse to MCSE
- lc_authentication_id  out  ID_W  authentication ID to MCSE
- lc_authentication_valid  out  1  authentication valid to MCSE
- busy  out  1  sequence in progress
- done  out  1  sticky: sequence completed
- err  out  1  sticky: start refused or sequence aborted

Behaviour:
- Reset: all outputs 0, state IDLE, both word counters 0, both full flags 0, both ID registers 0.
- Loading:
  - wr_ready = (state==IDLE) && !full[wr_sel] && !abort.
  - A write transfers when wr_valid && wr_ready. Word k of a target lands in bits [k*WORD_W +: WORD_W]; first word is least significant.
  - The per-target counter increments per write. When it wraps from ID_W/WORD_W-1 to 0, full[sel] is set.
  - Writes to a full target stall (wr_ready=0); no overwrite.
- States: IDLE, REQ, WAIT, AUTH, DONE.
- IDLE:
  - start && full[0] && full[1] && !abort -> REQ; clear done/err on the same edge.
  - start without both full -> stay IDLE, err=1.
- REQ, one cycle: lc_transition_request_in=1. Next state is WAIT if AUTH_GAP>0, else AUTH.
- WAIT: AUTH_GAP cycles (down-counter), then AUTH.
- AUTH: lc_authentication_valid=1 for exactly AUTH_HOLD cycles, then DONE.
- DONE, one cycle: done set (sticky), then IDLE. Full flags and counters cleared unless the feature below says otherwise.
- Output gating:
  - lc_transition_id = transition register in REQ, WAIT and AUTH; 0 otherwise.
  - lc_authentication_id = authentication register in AUTH only; 0 otherwise.
  - busy = 1 in REQ, WAIT, AUTH, DONE.
- Timing, start sampled at cycle T:
  - request high at T+1;
  - auth valid high T+2+AUTH_GAP through T+1+AUTH_GAP+AUTH_HOLD;
  - done first visible at T+2+AUTH_GAP+AUTH_HOLD.
- Abort:
  - In any non-IDLE state: next cycle IDLE; all lc_* outputs 0; err=1; full flags and counters cleared.
  - In IDLE: clears full flags and counters; err unchanged.
  - abort wins over start and over a write in the same cycle.
- done and err clear only on reset or an accepted start.
- rst mid-sequence: next cycle all outputs 0, state IDLE.

Optional Feature:
- Macro LC_ID_ZEROIZE_EN.
- Defined: on DONE and on abort, both ID registers are zeroed and full flags cleared. A start after DONE without reloading sets err.
- Undefined: ID registers are retained. On DONE, full flags stay set, so a second start replays the same IDs without reloading. Abort still clears the full flags; register contents are retained.

Test Plan:
- Load transition words 0x11111111..0x88888888 (sel 0) and auth words 0xA0000000..0xA0000007 (sel 1); start at T, defaults -> request high only at T+1 with lc_transition_id = 0x88888888_..._11111111; auth valid high T+6..T+13; done at T+14; busy low at T+15.
- Start with only 5 transition words loaded -> no request pulse, err=1, busy=0; the 6th write is still accepted.
- Write a 9th word to sel 0 -> wr_ready=0 for sel 0 while sel 1 writes still complete.
- Abort asserted at T+4 during WAIT -> lc_* outputs 0 at T+5, err=1, auth valid never asserted; start without reload -> err stays 1, no request.
- AUTH_GAP=0, AUTH_HOLD=1 -> request at T+1, auth valid only at T+2, done at T+3.
- Complete a sequence, then start again without writes -> LC_ID_ZEROIZE_EN defined: err=1; undefined: identical replay of IDs and timing.

Source files
------------

// File: rtl/lc_request_sequencer.sv
// rtl/lc_request_sequencer.sv - host-loaded lifecycle ID sequencer driving the MCSE request/auth inputs
// Optional macro LC_ID_ZEROIZE_EN: wipe both ID registers and full flags on DONE and on abort.
module lc_request_sequencer #(
    parameter int WORD_W    = 32,
    parameter int ID_W      = 256,
    parameter int AUTH_GAP  = 4,
    parameter int AUTH_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_sel,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    input  logic              abort,
    output logic [ID_W-1:0]   lc_transition_id,
    output logic              lc_transition_request_in,
    output logic [ID_W-1:0]   lc_authentication_id,
    output logic              lc_authentication_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int WORDS  = ID_W / WORD_W;
    localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PH_MAX = (AUTH_GAP > AUTH_HOLD) ? AUTH_GAP : AUTH_HOLD;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0]  GAP_LD    = PH_W'((AUTH_GAP > 0) ? AUTH_GAP - 1 : 0);
    localparam logic [PH_W-1:0]  HOLD_LD   = PH_W'(AUTH_HOLD - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_AUTH, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [PH_W-1:0]   ph_cnt;
    logic [CNT_W-1:0]  wcnt [2];
    logic [ID_W-1:0]   id_reg [2];
    logic [1:0]        full;
    logic              wr_fire;
    logic              start_ok;
    logic              clear_load;

    assign wr_ready = (state == S_IDLE) && !full[wr_sel] && !abort;
    assign wr_fire  = wr_valid && wr_ready;
    assign start_ok = (state == S_IDLE) && start && (&full) && !abort;

    // Index 0 holds the transition ID, index 1 the authentication ID.
`ifdef LC_ID_ZEROIZE_EN
    assign clear_load = abort || (state == S_DONE);
`else
    assign clear_load = abort;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_REQ;
            S_REQ:   state_nxt = (AUTH_GAP > 0) ? S_WAIT : S_AUTH;
            S_WAIT:  if (ph_cnt == '0) state_nxt = S_AUTH;
            S_AUTH:  if (ph_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ph_cnt    <= '0;
            wcnt[0]   <= '0;
            wcnt[1]   <= '0;
            id_reg[0] <= '0;
            id_reg[1] <= '0;
            full      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;

            // Shared down-counter: gap length in WAIT, then hold length in AUTH.
            case (state)
                S_REQ:   ph_cnt <= (AUTH_GAP > 0) ? GAP_LD : HOLD_LD;
                S_WAIT:  ph_cnt <= (ph_cnt == '0) ? HOLD_LD : ph_cnt - PH_W'(1);
                S_AUTH:  ph_cnt <= ph_cnt - PH_W'(1);
                default: ph_cnt <= ph_cnt;
            endcase

            if (wr_fire) begin
                id_reg[wr_sel][wcnt[wr_sel]*WORD_W +: WORD_W] <= wr_data;
                if (wcnt[wr_sel] == LAST_WORD) begin
                    wcnt[wr_sel] <= '0;
                    full[wr_sel] <= 1'b1;
                end else begin
                    wcnt[wr_sel] <= wcnt[wr_sel] + CNT_W'(1);
                end
            end

            if (start_ok) begin
                done <= 1'b0;
                err  <= 1'b0;
            end else if ((state == S_IDLE) && start && !abort) begin
                err <= 1'b1;
            end
            if (abort && (state != S_IDLE)) err <= 1'b1;
            if ((state == S_AUTH) && (ph_cnt == '0) && !abort) done <= 1'b1;

            if (clear_load) begin
                wcnt[0] <= '0;
                wcnt[1] <= '0;
                full    <= '0;
`ifdef LC_ID_ZEROIZE_EN
                id_reg[0] <= '0;
                id_reg[1] <= '0;
`endif
            end
        end
    end

    assign lc_transition_request_in = (state == S_REQ);
    assign lc_authentication_valid  = (state == S_AUTH);
    assign lc_transition_id     = ((state == S_REQ) || (state == S_WAIT) || (state == S_AUTH))
                                  ? id_reg[0] : '0;
    assign lc_authentication_id = (state == S_AUTH) ? id_reg[1] : '0;
    assign busy                 = (state != S_IDLE);

endmodule

// File: tb/tb_lc_request_sequencer.sv
// tb/tb_lc_request_sequencer.sv - randomized bench for lc_request_sequencer against a timestamp model
module tb_lc_request_sequencer;
    localparam int WORDS = 8;
    localparam logic [255:0] TID_REF =
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

    logic         clk = 1'b0;
    logic         rst, wr_valid, wr_sel, start, abort;
    logic [31:0]  wr_data;
    logic [1:0]   rdy, req, av, busy, done, err;
    logic [255:0] tid_o [2];
    logic [255:0] aid_o [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lc_request_sequencer u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[0]), .wr_sel(wr_sel),
        .wr_data(wr_data), .start(start), .abort(abort),
        .lc_transition_id(tid_o[0]), .lc_transition_request_in(req[0]),
        .lc_authentication_id(aid_o[0]), .lc_authentication_valid(av[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    lc_request_sequencer #(.AUTH_GAP(0), .AUTH_HOLD(1)) u_dut_fast (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[1]), .wr_sel(wr_sel),
        .wr_data(wr_data), .start(start), .abort(abort),
        .lc_transition_id(tid_o[1]), .lc_transition_request_in(req[1]),
        .lc_authentication_id(aid_o[1]), .lc_authentication_valid(av[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // Model: m_ph = cycles since the accepted start (REQ is 1), -1 when idle.
    int           gap  [2];
    int           hold [2];
    int           m_ph [2];
    int           m_cnt [2][2];
    logic [255:0] m_id [2][2];
    logic         m_done [2];
    logic         m_err [2];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_ready(input int i, input logic s, input logic ab);
        return (m_ph[i] < 0) && (m_cnt[i][s] < WORDS) && !ab;
    endfunction

    task automatic m_clear(input int i);
        m_cnt[i][0] = 0;
        m_cnt[i][1] = 0;
`ifdef LC_ID_ZEROIZE_EN
        m_id[i][0] = '0;
        m_id[i][1] = '0;
`endif
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = -1;
            m_done[i] = 1'b0;
            m_err[i] = 1'b0;
            m_cnt[i][0] = 0;
            m_cnt[i][1] = 0;
            m_id[i][0] = '0;
            m_id[i][1] = '0;
        end
    endtask

    task automatic cycle(input logic r, input logic wv, input logic ws, input logic [31:0] wd,
                         input logic st, input logic ab);
        rst = r; wr_valid = wv; wr_sel = ws; wr_data = wd; start = st; abort = ab;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int  d;
            int  last;
            logic e_av;
            d = m_ph[i];
            last = 2 + gap[i] + hold[i];
            e_av = (d >= 2 + gap[i]) && (d <= 1 + gap[i] + hold[i]);
            check($sformatf("wr_ready[%0d]", i), 256'(rdy[i]), 256'(m_ready(i, ws, ab)));
            check($sformatf("req[%0d]", i), 256'(req[i]), 256'(d == 1));
            check($sformatf("auth_valid[%0d]", i), 256'(av[i]), 256'(e_av));
            check($sformatf("tid[%0d]", i), tid_o[i],
                  (d >= 1 && d <= 1 + gap[i] + hold[i]) ? m_id[i][0] : '0);
            check($sformatf("aid[%0d]", i), aid_o[i], e_av ? m_id[i][1] : '0);
            check($sformatf("busy[%0d]", i), 256'(busy[i]), 256'(d >= 1));
            check($sformatf("done[%0d]", i), 256'(done[i]), 256'(m_done[i]));
            check($sformatf("err[%0d]", i), 256'(err[i]), 256'(m_err[i]));
        end
        for (int i = 0; i < 2; i++) begin
            int   last;
            logic rdy_m;
            logic both;
            last = 2 + gap[i] + hold[i];
            rdy_m = m_ready(i, ws, ab);
            both = (m_cnt[i][0] == WORDS) && (m_cnt[i][1] == WORDS);
            if (r) begin
                // handled after loop
            end else if (m_ph[i] >= 1) begin
                if (ab) begin
                    m_ph[i] = -1;
                    m_err[i] = 1'b1;
                    m_clear(i);
                end else if (m_ph[i] == last) begin
                    m_ph[i] = -1;
`ifdef LC_ID_ZEROIZE_EN
                    m_clear(i);
`endif
                end else begin
                    m_ph[i]++;
                    if (m_ph[i] == last) m_done[i] = 1'b1;
                end
            end else if (ab) begin
                m_clear(i);
            end else begin
                if (wv && rdy_m) begin
                    m_id[i][ws][m_cnt[i][ws]*32 +: 32] = wd;
                    m_cnt[i][ws]++;
                end
                if (st && both) begin
                    m_ph[i] = 1;
                    m_done[i] = 1'b0;
                    m_err[i] = 1'b0;
                end else if (st) begin
                    m_err[i] = 1'b1;
                end
            end
        end
        if (r) m_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic s, input int n, input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, s, base + step * 32'(k), 1'b0, 1'b0);
    endtask

    initial begin
        gap[0] = 4; hold[0] = 8;
        gap[1] = 0; hold[1] = 1;
        rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_data = '0; start = 1'b0; abort = 1'b0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h5, 1'b1, 1'b0);

        // Full load, overflow stall on sel 0, then a nominal sequence.
        load(1'b0, 8, 32'h11111111, 32'h11111111);
        cycle(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        load(1'b1, 8, 32'hA0000000, 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("seq_req", 256'(req[0]), 256'(1));
        check("seq_tid", tid_o[0], TID_REF);
        idle(13);
        check("seq_done", 256'(done[0]), 256'(1));
        check("seq_busy_done", 256'(busy[0]), 256'(1));
        idle(1);
        check("seq_busy_end", 256'(busy[0]), 256'(0));

        // Second start without reload.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef LC_ID_ZEROIZE_EN
        check("replay_err", 256'(err[0]), 256'(1));
        check("replay_req", 256'(req[0]), 256'(0));
`else
        check("replay_req", 256'(req[0]), 256'(1));
        check("replay_tid", tid_o[0], TID_REF);
`endif
        idle(15);

        // Abort during WAIT, then start without reload.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        load(1'b0, 8, 32'h11111111, 32'h11111111);
        load(1'b1, 8, $urandom, 32'h01010101);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(3);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("abort_req", 256'(req[0]), 256'(0));
        check("abort_tid", tid_o[0], '0);
        check("abort_err", 256'(err[0]), 256'(1));
        check("abort_busy", 256'(busy[0]), 256'(0));
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("abort_restart_err", 256'(err[0]), 256'(1));
        check("abort_restart_req", 256'(req[0]), 256'(0));

        // Partial load refused, then loading continues.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        load(1'b0, 5, 32'h1, 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("partial_err", 256'(err[0]), 256'(1));
        check("partial_busy", 256'(busy[0]), 256'(0));
        load(1'b0, 3, 32'h6, 32'h1);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  $urandom, ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
